// File: rtl/oclib_csr_arbiter.sv
// Round-robin arbiter sharing one 32-bit CSR target between several upstream CSR masters.
// Optional hung-target timeout enabled by defining OCLIB_CSR_ARBITER_TIMEOUT_EN.
package oclib_pkg;
    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
    } csr_32_s;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        error;
    } csr_32_fb_s;
endpackage

module oclib_csr_arbiter #(
    parameter int  Requesters    = 2,
    parameter int  TimeoutCycles = 1024,
    localparam int IdW           = (Requesters > 1) ? $clog2(Requesters) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  oclib_pkg::csr_32_s    in     [Requesters],
    output oclib_pkg::csr_32_fb_s inFb   [Requesters],
    output oclib_pkg::csr_32_s    out,
    input  oclib_pkg::csr_32_fb_s outFb,
    output logic [IdW-1:0]        grantId,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RECOVER} state_t;

    state_t                r_state;
    state_t                w_state_next;
    oclib_pkg::csr_32_s    r_out;
    oclib_pkg::csr_32_fb_s r_infb [Requesters];
    logic [IdW-1:0]        r_grant;
    logic [IdW-1:0]        r_last;
    logic [Requesters-1:0] r_pending_drop;
    logic [Requesters-1:0] w_req;
    logic [IdW-1:0]        w_sel;
    logic                  w_any;
    logic                  w_timeout;

    // A master that just got its ready pulse stays ineligible until it shows one idle cycle.
    always_comb begin
        for (int i = 0; i < Requesters; i++) begin
            w_req[i] = (in[i].read | in[i].write) & ~r_pending_drop[i];
        end
    end

    always_comb begin : rr_pick
        int idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel = '0;
        w_any = 1'b0;
        idx   = 0;
        for (int k = 1; k <= Requesters; k++) begin
            idx = int'(r_last) + k;
            if (idx >= Requesters) idx = idx - Requesters;
            if (!w_any && w_req[idx]) begin
                w_sel = IdW'(idx);
                w_any = 1'b1;
            end
        end
    end

`ifdef OCLIB_CSR_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] r_timer;

    // Held at zero outside ISSUE, so it starts from zero on every ISSUE entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == ISSUE) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    assign w_timeout = (r_state == ISSUE) && !outFb.ready &&
                       (r_timer == TW'(TimeoutCycles - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_next = ISSUE;
            ISSUE:   if (outFb.ready || w_timeout) w_state_next = RECOVER;
            RECOVER: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments override defaults.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out          <= '0;
            r_grant        <= '0;
            r_last         <= IdW'(Requesters - 1);
            r_pending_drop <= '0;
            for (int i = 0; i < Requesters; i++) r_infb[i] <= '0;
        end else begin
            for (int i = 0; i < Requesters; i++) begin
                r_infb[i] <= '0;
                if (!(in[i].read | in[i].write)) r_pending_drop[i] <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_out   <= in[w_sel];
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                    end
                end
                ISSUE: begin
                    if (outFb.ready || w_timeout) begin
                        r_infb[r_grant].ready    <= 1'b1;
                        r_infb[r_grant].rdata    <= outFb.ready ? outFb.rdata : 32'hdeadc0de;
                        r_infb[r_grant].error    <= outFb.ready ? outFb.error : 1'b1;
                        r_out.read               <= 1'b0;
                        r_out.write              <= 1'b0;
                        r_pending_drop[r_grant]  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out     = r_out;
    assign inFb    = r_infb;
    assign grantId = r_grant;
    assign busy    = (r_state == ISSUE) || (r_state == RECOVER);
endmodule
